// File: rtl/spectral_mask_stream.sv
// spectral_mask_stream
//   Streams one FFT frame of complex bins out of the spectrum RAM and applies a
//   per-bin gain code from a conjugate-mirrored mask table. The result goes out
//   on a valid/ready stream with last.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, bypass       frame start pulse (IDLE only); bypass is latched at start
//   busy                high from accepted start until the last bin handshakes
//   ram_rd, ram_addr    RAM read strobe and bin address
//   ram_data            RAM read data, RAM_LAT cycles after ram_rd
//   cfg_we/addr/code    mask table write (idle only, addr <= N/2)
//   cfg_ack             write-accepted pulse
//   m_data/valid/ready  output stream; m_last marks bin N-1
//   frame_done          pulse the cycle after the last handshake
module spectral_mask_stream #(
   parameter int FFT_LOG2 = 10,
   parameter int DW       = 16,
   parameter int RAM_LAT  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                bypass,
   output logic                busy,
   output logic                ram_rd,
   output logic [FFT_LOG2-1:0] ram_addr,
   input  logic [2*DW-1:0]     ram_data,
   input  logic                cfg_we,
   input  logic [FFT_LOG2-1:0] cfg_addr,
   input  logic [1:0]          cfg_code,
   output logic                cfg_ack,
   output logic [2*DW-1:0]     m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_last,
   output logic                frame_done
);

   localparam int N     = 1 << FFT_LOG2;
   localparam int HALF  = N / 2;
   localparam int DEPTH = RAM_LAT + 2;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int SW    = 8;

   localparam logic [FFT_LOG2:0]   N_V    = (FFT_LOG2+1)'(N);
   localparam logic [FFT_LOG2:0]   HALF_V = (FFT_LOG2+1)'(HALF);
   localparam logic [FFT_LOG2-1:0] LAST_V = FFT_LOG2'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                r_state, w_next;
   logic [FFT_LOG2-1:0]   r_cnt;
   logic                  r_bypass;
   logic [1:0]            r_tbl [0:HALF];
   logic                  r_rd;
   logic [FFT_LOG2-1:0]   r_raddr;
   logic [RAM_LAT-1:0]    r_vld;
   logic [FFT_LOG2-1:0]   r_vidx [RAM_LAT];
   logic [2*DW-1:0]       r_fdata [DEPTH];
   logic                  r_flast [DEPTH];
   logic [PW-1:0]         r_wptr, r_rptr;
   logic [CW-1:0]         r_count;
   logic                  r_ack, r_done;

   logic                  w_issue, w_wr, w_pop, w_valid;
   logic [SW-1:0]         w_infl, w_occ;
   logic [FFT_LOG2-1:0]   w_widx, w_j;
   logic [FFT_LOG2:0]     w_k_ext, w_j_ext;
   logic [1:0]            w_code;
   logic signed [DW-1:0]  w_re, w_im;
   logic [2*DW-1:0]       w_masked;
   logic                  w_cfg_ok;

   // Credit check counts everything issued but not yet popped: the read
   // register, the RAM pipeline and the FIFO. A pop in the same cycle frees a
   // slot, which keeps the stream gap-free when m_ready stays high.
   always_comb begin
      w_infl = SW'(r_rd);
      for (int unsigned i = 0; i < RAM_LAT; i++) begin
         w_infl = w_infl + SW'(r_vld[i]);
      end
   end

   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid & m_ready;
   assign w_occ   = SW'(r_count) + w_infl - SW'(w_pop);
   assign w_issue = (r_state == S_RUN) && (w_occ < SW'(DEPTH));

   // FSM
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_issue && (r_cnt == LAST_V)) w_next = S_DRAIN;
         S_DRAIN: if (w_pop && r_flast[r_rptr]) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Issue counter, bypass latch and registered RAM read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_bypass <= 1'b0;
         r_rd     <= 1'b0;
         r_raddr  <= '0;
      end else begin
         r_rd <= w_issue;
         if (w_issue) r_raddr <= r_cnt;
         if (r_state == S_IDLE) begin
            r_cnt <= '0;
            if (start) r_bypass <= bypass;
         end else if (w_issue) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Read-data valid/index pipeline aligned with the RAM latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= r_rd;
         for (int unsigned i = 1; i < RAM_LAT; i++) r_vld[i] <= r_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      r_vidx[0] <= r_raddr;
      for (int unsigned i = 1; i < RAM_LAT; i++) r_vidx[i] <= r_vidx[i-1];
   end

   assign w_wr   = r_vld[RAM_LAT-1];
   assign w_widx = r_vidx[RAM_LAT-1];

   // Mirror bins above Nyquist onto their conjugate partner's table entry.
   assign w_k_ext = {1'b0, w_widx};
   assign w_j_ext = (w_k_ext <= HALF_V) ? w_k_ext : (N_V - w_k_ext);
   assign w_j     = w_j_ext[FFT_LOG2-1:0];
   assign w_code  = r_bypass ? 2'b00 : r_tbl[w_j];
   assign w_re    = ram_data[2*DW-1:DW];
   assign w_im    = ram_data[DW-1:0];

   always_comb begin
      w_masked = ram_data;
      case (w_code)
         2'b01:   w_masked = {w_re >>> 1, w_im >>> 1};
         2'b10:   w_masked = {w_re >>> 2, w_im >>> 2};
         2'b11:   w_masked = '0;
         default: w_masked = ram_data;
      endcase
   end

   // Output FIFO; the write into it is the mask register stage.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_fdata[r_wptr] <= w_masked;
         r_flast[r_wptr] <= (w_widx == LAST_V);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr)  r_wptr <= (r_wptr == PW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
         if (w_pop) r_rptr <= (r_rptr == PW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
         r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      end
   end

   // Mask table and config handshake.
   assign w_cfg_ok = cfg_we && (r_state == S_IDLE) && ({1'b0, cfg_addr} <= HALF_V);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < HALF + 1; i++) r_tbl[i] <= 2'b00;
         r_ack  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         if (w_cfg_ok) r_tbl[cfg_addr] <= cfg_code;
         r_ack  <= w_cfg_ok;
         r_done <= w_pop && r_flast[r_rptr];
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign ram_rd     = r_rd;
   assign ram_addr   = r_raddr;
   assign cfg_ack    = r_ack;
   assign frame_done = r_done;
   assign m_valid    = w_valid;
   assign m_data     = w_valid ? r_fdata[r_rptr] : '0;
   assign m_last     = w_valid & r_flast[r_rptr];

endmodule
